// File: rtl/rcpu_pkg.sv
// Shared constants and types for the CPU-side RAM and its arbiter.
package rcpu_pkg;
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  localparam int RAM_DEPTH      = 4096;
  localparam int WORD_W         = 16;
  localparam int ADDR_W         = 16;
  localparam int MEM_RD_LATENCY = 1;

  typedef struct packed {
    logic any;  // some requester is served this cycle
    logic id;   // which one (valid only when any=1)
  } grant_t;
endpackage

// File: rtl/ram_arb_pick.sv
// Combinational round-robin pick with burst limit: stay with the owner unless it
// has used its burst while the other requester waits.
module ram_arb_pick #(
  parameter int MAX_BURST = 4
) (
  input  logic                  owner_i,
  input  logic [3:0]            burst_cnt_i,
  input  logic                  rq0_vld_i,
  input  logic                  rq1_vld_i,
  output rcpu_pkg::grant_t      grant_o
);
  import rcpu_pkg::*;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  logic own_vld;
  logic oth_vld;
  logic limit_hit;

  always_comb begin
    own_vld   = (owner_i == REQ_LDR) ? rq1_vld_i : rq0_vld_i;
    oth_vld   = (owner_i == REQ_LDR) ? rq0_vld_i : rq1_vld_i;
    limit_hit = (burst_cnt_i == BURST_LIM) && oth_vld;

    grant_o.any = 1'b0;
    grant_o.id  = owner_i;
    if (own_vld && !limit_hit) begin
      grant_o.any = 1'b1;
      grant_o.id  = owner_i;
    end else if (oth_vld) begin
      grant_o.any = 1'b1;
      grant_o.id  = ~owner_i;
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a 1-cycle-latency synchronous RAM; one access
// per cycle, accepted combinationally, read data returned to the issuer next cycle.
module ram_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic              rq0_valid,
  input  logic              rq0_we,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  output logic              rq0_ready,
  output logic              rs0_valid,
  output logic [DATA_W-1:0] rs0_rdata,
  input  logic              rq1_valid,
  input  logic              rq1_we,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  output logic              rq1_ready,
  output logic              rs1_valid,
  output logic [DATA_W-1:0] rs1_rdata,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);
  import rcpu_pkg::*;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  logic       owner_q, owner_d;
  logic [3:0] burst_q, burst_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_id_q, rd_id_d;

  grant_t            grant;
  logic              acc;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  ram_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
    .owner_i     (owner_q),
    .burst_cnt_i (burst_q),
    .rq0_vld_i   (rq0_valid),
    .rq1_vld_i   (rq1_valid),
    .grant_o     (grant)
  );

  // Gating with resetq keeps every output at 0 while reset is held.
  always_comb begin
    acc       = grant.any & resetq;
    sel_we    = (grant.id == REQ_LDR) ? rq1_we    : rq0_we;
    sel_addr  = (grant.id == REQ_LDR) ? rq1_addr  : rq0_addr;
    sel_wdata = (grant.id == REQ_LDR) ? rq1_wdata : rq0_wdata;

    rq0_ready         = acc & (grant.id == REQ_CPU);
    rq1_ready         = acc & (grant.id == REQ_LDR);
    mem_write_enable  = acc & sel_we;
    mem_read_enable   = acc & ~sel_we;
    mem_write_address = mem_write_enable ? sel_addr  : '0;
    mem_write_data    = mem_write_enable ? sel_wdata : '0;
    mem_read_address  = mem_read_enable  ? sel_addr  : '0;

    rs0_valid = rd_pend_q & (rd_id_q == REQ_CPU);
    rs1_valid = rd_pend_q & (rd_id_q == REQ_LDR);
    rs0_rdata = resetq ? mem_read_data : '0;
    rs1_rdata = resetq ? mem_read_data : '0;
  end

  always_comb begin
    owner_d   = owner_q;
    burst_d   = burst_q;
    rd_pend_d = grant.any & ~sel_we;
    rd_id_d   = grant.id;
    if (!grant.any) begin
      burst_d = 4'd0;
    end else if (grant.id == owner_q) begin
      burst_d = (burst_q == BURST_LIM) ? burst_q : burst_q + 4'd1;
    end else begin
      owner_d = grant.id;
      burst_d = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      owner_q   <= REQ_CPU;
      burst_q   <= 4'd0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= REQ_CPU;
    end else begin
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, grant-history reference model, vector table,
// directed corner sequences and randomized traffic.
module tb_ram_arbiter;
  localparam int MAX_BURST = 4;

  typedef struct {
    logic        v;
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  typedef struct {
    logic v0, v1;
    logic er0, er1;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        rq0_valid = 1'b0, rq0_we = 1'b0;
  logic [15:0] rq0_addr = '0, rq0_wdata = '0;
  logic        rq1_valid = 1'b0, rq1_we = 1'b0;
  logic [15:0] rq1_addr = '0, rq1_wdata = '0;
  logic        rq0_ready, rq1_ready, rs0_valid, rs1_valid;
  logic [15:0] rs0_rdata, rs1_rdata;
  logic        mem_read_enable, mem_write_enable;
  logic [15:0] mem_read_address, mem_write_address, mem_write_data;
  logic [15:0] mem_read_data;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .resetq(resetq),
    .rq0_valid(rq0_valid), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_ready(rq0_ready), .rs0_valid(rs0_valid), .rs0_rdata(rs0_rdata),
    .rq1_valid(rq1_valid), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_ready(rq1_ready), .rs1_valid(rs1_valid), .rs1_rdata(rs1_rdata),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // External 4096x16 synchronous RAM
  logic [15:0] ram [4096];
  logic [15:0] ram_q = '0;
  assign mem_read_data = ram_q;
  always @(posedge clk) begin
    if (mem_write_enable) ram[mem_write_address[11:0]] <= mem_write_data;
    if (mem_read_enable)  ram_q <= ram[mem_read_address[11:0]];
  end

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 7) ^ 16'h3C3C;
  endfunction

  // Reference model state: grant history (-1 = idle cycle) and a shadow memory
  int          hist[$];
  logic [15:0] shadow [4096];
  logic        exp_v0 = 1'b0, exp_v1 = 1'b0;
  logic [15:0] exp_dat = '0;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;

  logic        s_rdy0, s_rdy1, s_mwe, s_rs0_vld, s_rs1_vld;
  logic [15:0] s_rs_dat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic v, input logic we, input logic [15:0] a,
                              input logic [15:0] d);
    req_t r;
    r.v = v; r.we = we; r.addr = a; r.data = d;
    return r;
  endfunction

  task automatic chk_zero(input string name);
    chk(name, {31'd0, |{rq0_ready, rq1_ready, rs0_valid, rs1_valid, mem_read_enable,
                        mem_write_enable, mem_read_address, mem_write_address,
                        mem_write_data, rs0_rdata, rs1_rdata}}, 32'd0);
  endtask

  // Owner = most recent served requester; run = trailing grants to it with no gap.
  function automatic int model_pick(input logic v0, input logic v1);
    int own, run, oth;
    logic vv [2];
    own = 0;
    for (int i = hist.size() - 1; i >= 0; i--)
      if (hist[i] >= 0) begin own = hist[i]; break; end
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--)
      if (hist[i] == own) run++; else break;
    oth = 1 - own;
    vv[0] = v0; vv[1] = v1;
    if (vv[own] && !(run >= MAX_BURST && vv[oth])) return own;
    if (vv[oth]) return oth;
    return -1;
  endfunction

  task automatic do_cycle(input req_t r0, input req_t r1);
    int   srv;
    req_t rs;
    rq0_valid = r0.v; rq0_we = r0.we; rq0_addr = r0.addr; rq0_wdata = r0.data;
    rq1_valid = r1.v; rq1_we = r1.we; rq1_addr = r1.addr; rq1_wdata = r1.data;
    srv = model_pick(r0.v, r1.v);
    rs  = (srv == 1) ? r1 : r0;
    @(negedge clk);
    chk("rdy0", {31'd0, rq0_ready}, {31'd0, srv == 0});
    chk("rdy1", {31'd0, rq1_ready}, {31'd0, srv == 1});
    chk("mem_we", {31'd0, mem_write_enable}, {31'd0, (srv >= 0) && rs.we});
    chk("mem_re", {31'd0, mem_read_enable}, {31'd0, (srv >= 0) && !rs.we});
    if (srv >= 0 && rs.we) begin
      chk("mem_waddr", {16'd0, mem_write_address}, {16'd0, rs.addr});
      chk("mem_wdata", {16'd0, mem_write_data}, {16'd0, rs.data});
    end
    if (srv >= 0 && !rs.we) chk("mem_raddr", {16'd0, mem_read_address}, {16'd0, rs.addr});
    chk("rs0_vld", {31'd0, rs0_valid}, {31'd0, exp_v0});
    chk("rs1_vld", {31'd0, rs1_valid}, {31'd0, exp_v1});
    if (exp_v0) chk("rs0_dat", {16'd0, rs0_rdata}, {16'd0, exp_dat});
    if (exp_v1) chk("rs1_dat", {16'd0, rs1_rdata}, {16'd0, exp_dat});
    s_rdy0 = rq0_ready; s_rdy1 = rq1_ready; s_mwe = mem_write_enable;
    s_rs0_vld = rs0_valid; s_rs1_vld = rs1_valid; s_rs_dat = rs0_rdata;
    if (mem_write_enable) wr_pulses++;
    @(posedge clk);
    hist.push_back(srv);
    if (hist.size() > 32) void'(hist.pop_front());
    exp_v0 = (srv == 0) && !rs.we;
    exp_v1 = (srv == 1) && !rs.we;
    if (srv >= 0 && !rs.we) exp_dat = shadow[rs.addr[11:0]];
    if (srv >= 0 && rs.we)  shadow[rs.addr[11:0]] = rs.data;
    #1;
  endtask

  task automatic do_reset(input int ncyc, input req_t r0);
    resetq = 1'b0;
    rq0_valid = r0.v; rq0_we = r0.we; rq0_addr = r0.addr; rq0_wdata = r0.data;
    rq1_valid = 1'b0; rq1_we = 1'b0;
    hist.delete();
    exp_v0 = 1'b0; exp_v1 = 1'b0;
    repeat (ncyc) begin
      @(negedge clk);
      chk_zero("reset_outputs");
    end
    @(posedge clk);
    #1 resetq = 1'b1;
  endtask

  vec_t tbl [16];
  req_t idle;

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
    ram[5] <= 16'hBEEF;
  end

  initial begin
    logic g3 [9];
    logic g6 [4];
    for (int i = 0; i < 4096; i++) shadow[i] = init_val(i);
    shadow[5] = 16'hBEEF;
    idle = mk(1'b0, 1'b0, 16'h0, 16'h0);

    // 1: reset with rq0 pending, then first read
    do_reset(3, mk(1'b1, 1'b0, 16'h0005, 16'h0));
    do_cycle(mk(1'b1, 1'b0, 16'h0005, 16'h0), idle);
    chk("t1_ready0", {31'd0, s_rdy0}, 32'd1);
    do_cycle(idle, idle);
    chk("t1_rs0_vld", {31'd0, s_rs0_vld}, 32'd1);
    chk("t1_rs1_vld", {31'd0, s_rs1_vld}, 32'd0);
    chk("t1_rs0_dat", {16'd0, s_rs_dat}, 32'h0000BEEF);

    // 2: lone loader streams 10 writes, never throttled
    wr_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      do_cycle(idle, mk(1'b1, 1'b1, 16'(16'h0100 + i), 16'(16'hA000 + i)));
      chk("t2_ready1", {31'd0, s_rdy1}, 32'd1);
    end
    chk("t2_wr_pulses", 32'(wr_pulses), 32'd10);

    // 3: both reading continuously from reset
    do_reset(1, idle);
    g3 = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 9; i++) begin
      do_cycle(mk(1'b1, 1'b0, 16'(i), 16'h0), mk(1'b1, 1'b0, 16'(16'h0100 + i), 16'h0));
      chk("t3_grant", {31'd0, s_rdy1}, {31'd0, g3[i]});
    end
    do_cycle(idle, idle);

    // 4: write then read of the same address by the other requester
    do_cycle(mk(1'b1, 1'b1, 16'h0042, 16'h1234), idle);
    do_cycle(idle, mk(1'b1, 1'b0, 16'h0042, 16'h0));
    do_cycle(idle, idle);
    chk("t4_rs1_vld", {31'd0, s_rs1_vld}, 32'd1);
    chk("t4_rs1_dat", {16'd0, s_rs_dat}, 32'h00001234);

    // Vector table from reset: {v0, v1, expected ready0, ready1}
    tbl = '{'{1,1,1,0}, '{1,1,1,0}, '{0,1,0,1}, '{1,1,0,1},
            '{1,1,0,1}, '{1,1,0,1}, '{1,1,1,0}, '{0,0,0,0},
            '{0,1,0,1}, '{1,0,1,0}, '{1,1,1,0}, '{1,1,1,0},
            '{1,1,1,0}, '{1,1,0,1}, '{0,0,0,0}, '{1,1,0,1}};
    do_reset(1, idle);
    for (int i = 0; i < 16; i++) begin
      do_cycle(mk(tbl[i].v0, 1'b0, 16'(i), 16'h0), mk(tbl[i].v1, 1'b0, 16'(i + 200), 16'h0));
      chk("tbl_ready0", {31'd0, s_rdy0}, {31'd0, tbl[i].er0});
      chk("tbl_ready1", {31'd0, s_rdy1}, {31'd0, tbl[i].er1});
    end

    // 6: owner drops out early; waiting requester served at once with a fresh burst
    do_reset(1, idle);
    do_cycle(mk(1'b1, 1'b0, 16'h10, 16'h0), mk(1'b1, 1'b0, 16'h20, 16'h0));
    do_cycle(mk(1'b1, 1'b0, 16'h11, 16'h0), mk(1'b1, 1'b0, 16'h21, 16'h0));
    do_cycle(idle, mk(1'b1, 1'b0, 16'h22, 16'h0));
    chk("t6_switch", {31'd0, s_rdy1}, 32'd1);
    g6 = '{1, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      do_cycle(mk(1'b1, 1'b0, 16'h12, 16'h0), mk(1'b1, 1'b0, 16'(16'h23 + i), 16'h0));
      chk("t6_burst", {31'd0, s_rdy1}, {31'd0, g6[i]});
    end
    do_cycle(idle, idle);

    // 5: reset 2 ns after a read is accepted drops its response
    do_cycle(mk(1'b1, 1'b0, 16'h0005, 16'h0), idle);
    #1 resetq = 1'b0;
    hist.delete();
    exp_v0 = 1'b0; exp_v1 = 1'b0;
    rq0_valid = 1'b0;
    #1 chk_zero("t5_reset_outputs");
    @(posedge clk);
    #2 resetq = 1'b1;
    do_cycle(idle, idle);
    chk("t5_no_rs0", {31'd0, s_rs0_vld}, 32'd0);
    do_cycle(mk(1'b1, 1'b0, 16'h7, 16'h0), mk(1'b1, 1'b0, 16'h8, 16'h0));
    chk("t5_first_owner", {31'd0, s_rdy0}, 32'd1);

    // Randomized traffic on a small address window to hit read-after-write
    for (int i = 0; i < 400; i++) begin
      do_cycle(mk(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                  16'($urandom_range(0, 15)), 16'($urandom)),
               mk(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                  16'($urandom_range(0, 15)), 16'($urandom)));
    end
    do_cycle(idle, idle);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single 4096x16 synchronous RAM (one write port, one read port, 1-cycle read latency) between two requesters:
  - requester 0: CPU data/fetch side;
  - requester 1: loader/DMA that fills or inspects memory while the CPU runs or is held.
- Sits between the requesters and the RAM's mem_* pins.
- Grants one access per cycle using round-robin with a burst limit, and routes read data back to the issuer.

Parameters:
- ADDR_W, 16, address width of requester and RAM ports.
- DATA_W, 16, data width.
- MAX_BURST, 4, max consecutive accepted accesses by one owner while the other requester is waiting; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetq  in  1  asynchronous, active-low reset.
- rq0_valid  in  1  requester 0 has an access pending.
- rq0_we  in  1  1=write, 0=read.
- rq0_addr  in  ADDR_W  access address.
- rq0_wdata  in  DATA_W  write data.
- rq0_ready  out  1  access accepted this cycle (valid&ready).
- rs0_valid  out  1  read data for requester 0 valid this cycle.
- rs0_rdata  out  DATA_W  read data.
- rq1_valid, rq1_we, rq1_addr, rq1_wdata, rq1_ready, rs1_valid, rs1_rdata: same as requester 0, for requester 1.
- mem_read_enable  out  1  RAM read strobe.
- mem_write_enable  out  1  RAM write strobe.
- mem_read_address  out  ADDR_W  RAM read address.
- mem_write_address  out  ADDR_W  RAM write address.
- mem_write_data  out  DATA_W  RAM write data.
- mem_read_data  in  DATA_W  RAM read data, valid 1 cycle after mem_read_enable.

Behaviour:
- Reset: one clock `clk`; reset `resetq` is asynchronous and active-low.
  - While resetq=0: owner=0, burst_cnt=0, rd_pend=0.
  - All outputs are 0: rq*_ready, rs*_valid, mem_*_enable, and address/data outputs.
  - Reset mid-read drops that read's response; no rs*_valid appears after release.
- State: owner (1 bit, last served), burst_cnt (4 bits), rd_pend (1 bit), rd_id (1 bit).
- Selection (combinational, same cycle as valid):
  - other = !owner.
  - If rq[owner]_valid and !(burst_cnt==MAX_BURST and rq[other]_valid): serve owner.
  - Else if rq[other]_valid: serve other.
  - Else: serve none.
  - rq[served]_ready=1; the other ready=0. Ready may depend on valid; requesters must not make valid depend on ready.
- Issue (same cycle as acceptance):
  - Write: mem_write_enable=1, mem_write_address/mem_write_data from served requester.
  - Read: mem_read_enable=1, mem_read_address from served requester.
  - Non-served values on address/data outputs are don't-care, but enables are exactly 0.
- State update on rising edge:
  - If served==owner: burst_cnt<=burst_cnt+1, saturating at MAX_BURST.
  - Else if served: owner<=served, burst_cnt<=1.
  - If none served: owner unchanged, burst_cnt<=0.
- Read return:
  - rd_pend<=accepted read; rd_id<=served.
  - Next cycle, rs[rd_id]_valid=1 for exactly one cycle; the other rs_valid stays 0.
  - rs0_rdata=rs1_rdata=mem_read_data (both unqualified outside rs_valid).
  - Latency from acceptance to data: 1 cycle. Back-to-back reads give one response per cycle.
- Writes produce no response. A write in cycle N followed by a read of the same address in cycle N+1 returns the new data.
- Lone requester: never throttled; burst limit applies only while the other is valid.
- Simultaneous first request from idle (owner=0, cnt=0, both valid): requester 0 served, then 1 after MAX_BURST if 0 stays valid.
- Fairness: a continuously valid requester waits at most MAX_BURST cycles.

Decomposition:
- Shared package rcpu_pkg:
  - REQ_CPU=0, REQ_LDR=1.
  - RAM_DEPTH=4096, WORD_W=16, ADDR_W=16.
  - MEM_RD_LATENCY=1.
- One natural sub-module: ram_arb_pick. Purely combinational: owner, burst_cnt, valids -> served/none.
- Response tracking and muxing stay in ram_arbiter.

Test Plan:
1. Reset held 3 cycles with rq0_valid=1: all outputs 0. Release with rq0 read addr 0x0005 (mem[5]=0xBEEF): rq0_ready same cycle, rs0_valid=1 with 0xBEEF next cycle, rs1_valid=0.
2. Only rq1 streams writes 0x0100..0x0109 for 10 cycles: 10 mem_write_enable pulses with addr/data matching, rq1_ready every cycle, no throttling.
3. Both valid continuously (reads), MAX_BURST=4, from reset: grant sequence 0,0,0,0,1,1,1,1,0,... Each rs*_valid appears 1 cycle after that requester's acceptance with correct data.
4. rq0 writes 0x0042<-0x1234 in cycle N; rq1 reads 0x0042 in N+1: rs1_rdata=0x1234 at N+2.
5. rq0 read accepted, resetq driven low 2 ns later for 1 cycle: no rs0_valid ever appears; after release owner=0 and the first both-valid cycle serves 0.
6. rq0 drops valid after 2 accesses while rq1 waits: rq1 served the next cycle (not after MAX_BURST); burst_cnt=1 for owner=1.
